fp32_to_bf16: RTL
=================

Name: fp32_to_bf16

Overview:
Streaming FP32-to-BFloat16 narrowing converter. It produces bf16 operands in the same split sign/exponent/mantissa field format that bf16_add consumes. It sits between FP32 sources (host loads, accumulators) and the bf16 datapath. It is a 2-stage pipeline with a valid/ready handshake on both sides, rounding per IEEE-754 and raising exception flags.

Parameters:
ROUND_MODE, 0, rounding: 0 = round-to-nearest-even (RNE), 1 = round-toward-zero (truncate).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
valid_i  in  1  input word valid
ready_o  out  1  converter can accept input this cycle
s_i  in  1  FP32 sign
e_i  in  8  FP32 exponent
m_i  in  23  FP32 mantissa
valid_o  out  1  output word valid
ready_i  in  1  downstream accepts output this cycle
s_o  out  1  bf16 sign
e_o  out  8  bf16 exponent
m_o  out  7  bf16 mantissa
inexact_o  out  1  result differs from input (bits discarded or flushed); qualified by valid_o
overflow_o  out  1  finite input rounded to infinity; qualified by valid_o

Behaviour:
- Interface: clk is the only clock. rst is synchronous and active-high.
- Reset: valid_o=0, s_o=0, e_o=0, m_o=0, inexact_o=0, overflow_o=0. Both internal stage valids are cleared.
- Reset mid-operation: all in-flight words are dropped with no partial output. ready_o=1 on the first cycle after rst deasserts.
- Pipeline enable: en = !valid_o || ready_i. ready_o = en (combinational).
- When en=1, both stages advance. Stage 1 captures valid_i & ready_o. Stage 2 captures stage 1.
- Latency is 2 cycles from accepted input to valid_o when not stalled. Throughput is 1 word/cycle. Bubbles are not collapsed.
- Stall (valid_o=1, ready_i=0): all output ports hold stable, ready_o=0, and no input is accepted.
- Simultaneous accept and emit in one cycle is legal and required.
- Stage 1 (round):
  - truncated mantissa t = m_i[22:16]
  - guard g = m_i[15]
  - sticky st = |m_i[14:0]
  - lsb l = m_i[16]
  - RNE: round-up u = g & (st | l). RTZ: u = 0.
  - {e,m} = {e_i, t} + u on 15 bits, so a mantissa carry increments the exponent.
  - inexact = g | st.
- Stage 2 (classify and pack), with priority:
  - NaN (e_i=FF, m_i!=0): s_o=s_i, e_o=FF, m_o={1'b1, m_i[21:16]} (quiet, never infinity). inexact=0, overflow=0.
  - Inf (e_i=FF, m_i=0): passed through. Flags 0.
  - Finite input whose rounded exponent reaches FF: e_o=FF, m_o=0, overflow=1, inexact=1.
  - Otherwise: the rounded {e, m}.
- Zero: ±0 passes through with its sign preserved. Flags 0.
- Subnormal input (e_i=0, m_i!=0): behaviour is set by the optional feature below.
- A subnormal that rounds up into the normal range yields e_o=01, m_o=00, which is correct by construction of the carry.
- Flags are only meaningful while valid_o=1; they are held with data during a stall.

Optional Feature:
DENORM_EN.
- Defined: subnormal inputs are rounded by the same stage 1 logic and produce bf16 subnormals.
- Undefined: subnormal inputs flush to signed zero (s_o=s_i, e_o=00, m_o=00) with inexact_o=1, overflow_o=0. Rounding is skipped.
- Normal, Inf and NaN paths are identical in both builds.

Test Plan:
- 1.0f (0x3F800000), ready_i=1 -> 2 cycles later s=0 e=7F m=00, inexact=0. Zero-flag checks: 0x80000000 -> s=1 e=00 m=00, flags 0.
- RNE ties and round-up:
  - 0x3F808000 (tie, lsb 0) -> e=7F m=00 inexact=1.
  - 0x3F818000 (tie, lsb 1) -> e=7F m=02 inexact=1.
  - With ROUND_MODE=1, 0x3F818000 -> m=01.
- Overflow: 0x7F7FFFFF -> RNE gives e=FF m=00 overflow=1 inexact=1. ROUND_MODE=1 gives e=FE m=7F overflow=0 inexact=1.
- NaN and Inf:
  - 0x7FC00001 -> e=FF m=40.
  - Signalling 0x7F800001 -> e=FF m=40.
  - 0xFF800000 -> s=1 e=FF m=00, flags 0.
- Subnormal 0x00400000 -> DENORM_EN defined: e=00 m=40 inexact=0. Undefined: e=00 m=00 inexact=1.
- Handshake stream:
  - Feed 4 back-to-back words and hold ready_i=0 for 3 cycles after the first output -> valid_o stays high, outputs are unchanged and ready_o=0.
  - Release ready_i -> all 4 words emerge in order with none lost or duplicated.
  - Assert rst mid-stream -> valid_o=0 next cycle and the prior words never appear.

Source files
------------

// File: rtl/fp32_to_bf16_if.sv
// Handshake and field bundle for the FP32 -> bf16 converter.
// slave = converter side, master = producer/consumer side.
interface fp32_to_bf16_if;
  logic        valid_i;
  logic        ready_o;
  logic        s_i;
  logic [7:0]  e_i;
  logic [22:0] m_i;
  logic        valid_o;
  logic        ready_i;
  logic        s_o;
  logic [7:0]  e_o;
  logic [6:0]  m_o;
  logic        inexact_o;
  logic        overflow_o;

  modport slave (
    input  valid_i, s_i, e_i, m_i, ready_i,
    output ready_o, valid_o, s_o, e_o, m_o, inexact_o, overflow_o
  );

  modport master (
    output valid_i, s_i, e_i, m_i, ready_i,
    input  ready_o, valid_o, s_o, e_o, m_o, inexact_o, overflow_o
  );
endinterface

// File: rtl/fp32_to_bf16.sv
// Two-stage streaming FP32 -> bf16 narrowing converter (round, then classify/pack).
// Define DENORM_EN to round subnormals to bf16 subnormals; otherwise they flush to signed zero.
module fp32_to_bf16 #(
  parameter int ROUND_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  fp32_to_bf16_if.slave bus
);

  logic        en;

  logic        vld_p1_d, vld_p1_q;
  logic        s_p1_d, s_p1_q;
  logic [14:0] em_p1_d, em_p1_q;
  logic        inexact_p1_d, inexact_p1_q;
  logic        nan_p1_d, nan_p1_q;
  logic        inf_p1_d, inf_p1_q;
  logic        flush_p1_d, flush_p1_q;
  logic [5:0]  nan_m_p1_d, nan_m_p1_q;

  logic        vld_p2_d, vld_p2_q;
  logic        s_p2_d, s_p2_q;
  logic [7:0]  e_p2_d, e_p2_q;
  logic [6:0]  m_p2_d, m_p2_q;
  logic        inexact_p2_d, inexact_p2_q;
  logic        overflow_p2_d, overflow_p2_q;

  function automatic logic round_up(input logic [22:0] m);
    logic g;
    logic st;
    logic l;
    g  = m[15];
    st = |m[14:0];
    l  = m[16];
    if (ROUND_MODE == 1) return 1'b0;
    return g & (st | l);
  endfunction

  // Rounding on the joined {exp, mant} lets a mantissa carry bump the exponent.
  function automatic logic [14:0] round_em(input logic [7:0] e, input logic [22:0] m);
    return {e, m[22:16]} + {14'd0, round_up(m)};
  endfunction

  assign en          = !vld_p2_q || bus.ready_i;
  assign bus.ready_o = en;

  // Stage 1: round
  always_comb begin
    vld_p1_d     = vld_p1_q;
    s_p1_d       = s_p1_q;
    em_p1_d      = em_p1_q;
    inexact_p1_d = inexact_p1_q;
    nan_p1_d     = nan_p1_q;
    inf_p1_d     = inf_p1_q;
    flush_p1_d   = flush_p1_q;
    nan_m_p1_d   = nan_m_p1_q;
    if (en) begin
      vld_p1_d     = bus.valid_i;
      s_p1_d       = bus.s_i;
      em_p1_d      = round_em(bus.e_i, bus.m_i);
      inexact_p1_d = bus.m_i[15] | (|bus.m_i[14:0]);
      nan_p1_d     = (bus.e_i == 8'hFF) && (bus.m_i != 23'd0);
      inf_p1_d     = (bus.e_i == 8'hFF) && (bus.m_i == 23'd0);
`ifdef DENORM_EN
      flush_p1_d   = 1'b0;
`else
      flush_p1_d   = (bus.e_i == 8'h00) && (bus.m_i != 23'd0);
`endif
      nan_m_p1_d   = bus.m_i[21:16];
    end
  end

  // Stage 2: classify and pack
  always_comb begin
    vld_p2_d      = vld_p2_q;
    s_p2_d        = s_p2_q;
    e_p2_d        = e_p2_q;
    m_p2_d        = m_p2_q;
    inexact_p2_d  = inexact_p2_q;
    overflow_p2_d = overflow_p2_q;
    if (en) begin
      vld_p2_d      = vld_p1_q;
      s_p2_d        = s_p1_q;
      inexact_p2_d  = 1'b0;
      overflow_p2_d = 1'b0;
      if (nan_p1_q) begin
        e_p2_d = 8'hFF;
        m_p2_d = {1'b1, nan_m_p1_q};
      end else if (inf_p1_q) begin
        e_p2_d = 8'hFF;
        m_p2_d = 7'd0;
      end else if (flush_p1_q) begin
        e_p2_d       = 8'h00;
        m_p2_d       = 7'd0;
        inexact_p2_d = 1'b1;
      end else if (em_p1_q[14:7] == 8'hFF) begin
        e_p2_d        = 8'hFF;
        m_p2_d        = 7'd0;
        inexact_p2_d  = 1'b1;
        overflow_p2_d = 1'b1;
      end else begin
        e_p2_d       = em_p1_q[14:7];
        m_p2_d       = em_p1_q[6:0];
        inexact_p2_d = inexact_p1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q      <= 1'b0;
      vld_p2_q      <= 1'b0;
      s_p2_q        <= 1'b0;
      e_p2_q        <= 8'd0;
      m_p2_q        <= 7'd0;
      inexact_p2_q  <= 1'b0;
      overflow_p2_q <= 1'b0;
    end else begin
      vld_p1_q      <= vld_p1_d;
      vld_p2_q      <= vld_p2_d;
      s_p2_q        <= s_p2_d;
      e_p2_q        <= e_p2_d;
      m_p2_q        <= m_p2_d;
      inexact_p2_q  <= inexact_p2_d;
      overflow_p2_q <= overflow_p2_d;
    end
  end

  // Stage-1 payload is only consumed when vld_p1_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    s_p1_q       <= s_p1_d;
    em_p1_q      <= em_p1_d;
    inexact_p1_q <= inexact_p1_d;
    nan_p1_q     <= nan_p1_d;
    inf_p1_q     <= inf_p1_d;
    flush_p1_q   <= flush_p1_d;
    nan_m_p1_q   <= nan_m_p1_d;
  end

  assign bus.valid_o    = vld_p2_q;
  assign bus.s_o        = s_p2_q;
  assign bus.e_o        = e_p2_q;
  assign bus.m_o        = m_p2_q;
  assign bus.inexact_o  = inexact_p2_q;
  assign bus.overflow_o = overflow_p2_q;

endmodule
